hazard_unit: RTL and testbench

- Stall/flush controller for the 5-stage RV32I pipeline; it complements the operand-forwarding logic.
- Covers the hazards that bypassing cannot resolve: load-use dependencies, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses.
- Drives stall enables, flushes and bubbles to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Holds a memory-wait FSM with a timeout watchdog, plus saturating stall/flush performance counters.

---
 rtl/hazard_if.sv | 45 ++++
 rtl/hazard_unit.sv | 117 +++++++++++
 tb/tb_hazard_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline-side bundle for the hazard unit: ID/EX/MEM hazard inputs and the
// stall/flush/bubble controls plus status and performance counters.
interface hazard_if #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32
);
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_address;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_address;
  logic                          ID_rs1_used;
  logic                          ID_rs2_used;
  logic                          EX_MemRead;
  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_address;
  logic                          EX_branch_taken;
  logic                          MEM_dmem_req;
  logic                          MEM_dmem_ready;

  logic                          PC_stall;
  logic                          IF_ID_stall;
  logic                          ID_EX_stall;
  logic                          EX_MEM_stall;
  logic                          IF_ID_flush;
  logic                          ID_EX_flush;
  logic                          MEM_WB_bubble;
  logic                          bus_error;
  logic [CNT_WIDTH-1:0]          stall_count;
  logic [CNT_WIDTH-1:0]          flush_count;

  modport master (
    output ID_Rs1_address, ID_Rs2_address, ID_rs1_used, ID_rs2_used,
           EX_MemRead, EX_Rd_address, EX_branch_taken,
           MEM_dmem_req, MEM_dmem_ready,
    input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
           bus_error, stall_count, flush_count
  );

  modport slave (
    input  ID_Rs1_address, ID_Rs2_address, ID_rs1_used, ID_rs2_used,
           EX_MemRead, EX_Rd_address, EX_branch_taken,
           MEM_dmem_req, MEM_dmem_ready,
    output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
           IF_ID_flush, ID_EX_flush, MEM_WB_bubble,
           bus_error, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, taken
// branch and multi-cycle dmem hazards, with a dmem timeout watchdog.
module hazard_unit #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT        = 16,
  parameter int CNT_WIDTH          = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t         state, state_n;
  logic [WW-1:0]  wcnt, wcnt_n;
  logic           startup;
  logic           bus_error_q;
  logic           set_error;
  logic           br_flush;
  logic           freeze;
  logic           lu_stall;
  logic           if_flush, id_flush;
  logic           mem_wait;
  logic           load_use;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  assign mem_wait = hz.MEM_dmem_req & ~hz.MEM_dmem_ready;
  assign load_use = hz.EX_MemRead && (hz.EX_Rd_address != '0) &&
                    ((hz.ID_rs1_used && (hz.EX_Rd_address == hz.ID_Rs1_address)) ||
                     (hz.ID_rs2_used && (hz.EX_Rd_address == hz.ID_Rs2_address)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wcnt        <= '0;
      startup     <= 1'b1;
      bus_error_q <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      startup <= 1'b0;
      if (set_error) bus_error_q <= 1'b1;
    end
  end

  // The startup cycle only clears IF/ID and ID/EX; FSM and counters hold.
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    set_error = 1'b0;
    br_flush  = 1'b0;
    freeze    = 1'b0;
    lu_stall  = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    if (startup) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_wait) begin
            freeze  = 1'b1;
            state_n = MEM_WAIT;
            wcnt_n  = WW'(1);
          end else if (hz.EX_branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            br_flush = 1'b1;
          end else if (load_use) begin
            lu_stall = 1'b1;
            id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.MEM_dmem_ready) begin
            state_n = RUN;
            wcnt_n  = '0;
          end else begin
            freeze = 1'b1;
            if (wcnt >= WW'(MEM_TIMEOUT - 1)) begin
              state_n   = ERROR;
              set_error = 1'b1;
            end else begin
              wcnt_n = wcnt + WW'(1);
            end
          end
        end
        ERROR:   freeze = 1'b1;
        default: state_n = RUN;
      endcase
    end
  end

  assign hz.PC_stall      = freeze | lu_stall;
  assign hz.IF_ID_stall   = freeze | lu_stall;
  assign hz.ID_EX_stall   = freeze;
  assign hz.EX_MEM_stall  = freeze;
  assign hz.MEM_WB_bubble = freeze;
  assign hz.IF_ID_flush   = if_flush;
  assign hz.ID_EX_flush   = id_flush;
  assign hz.bus_error     = bus_error_q;
  assign hz.stall_count   = stall_cnt_q;
  assign hz.flush_count   = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.PC_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_flush && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Vector-table bench for hazard_unit with 4-bit counters; expected outputs are
// queued when a vector is driven and compared when the outputs are sampled.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_if #(.REGFILE_ADDR_WIDTH(5), .CNT_WIDTH(4)) hz ();

  hazard_unit #(.REGFILE_ADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  // Output order: PC, IF/ID stall, ID/EX stall, EX/MEM stall, IF/ID flush, ID/EX flush, bubble
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] FREEZE = 7'b1111001;
  localparam logic [6:0] FLUSH  = 7'b0000110;
  localparam logic [6:0] LU     = 7'b1100010;

  typedef struct {
    logic       rst;
    logic       chk;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, bt, req, rdy;
    logic [6:0] o;
    logic       be;
    logic [3:0] sc, fc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic r, input logic [4:0] rs1, rs2, rd,
                             input logic u1, u2, mr, bt, req, rdy,
                             input logic [6:0] o, input logic be,
                             input logic [3:0] sc, fc);
    vec_t t;
    t.rst = r;   t.chk = ~r;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.u1 = u1;   t.u2 = u2;   t.mr = mr; t.bt = bt; t.req = req; t.rdy = rdy;
    t.o = o;     t.be = be;   t.sc = sc; t.fc = fc;
    return t;
  endfunction

  function automatic vec_t rst_v();
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
  endfunction

  function automatic vec_t idle(input logic [3:0] sc, fc);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, sc, fc);
  endfunction

  function automatic logic [3:0] sat(input int k);
    return (k > 15) ? 4'd15 : 4'(k);
  endfunction

  task automatic compare();
    vec_t       e;
    logic [6:0] o;
    e = sb.pop_front();
    if (!e.chk) return;
    n_vec++;
    o = {hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_stall, hz.EX_MEM_stall,
         hz.IF_ID_flush, hz.ID_EX_flush, hz.MEM_WB_bubble};
    if (o !== e.o) begin
      n_bad++;
      $display("FAIL ctrl vec%0d: got %b want %b", n_vec, o, e.o);
    end
    if (hz.bus_error !== e.be) begin
      n_bad++;
      $display("FAIL bus_error vec%0d: got %b want %b", n_vec, hz.bus_error, e.be);
    end
    if (hz.stall_count !== e.sc) begin
      n_bad++;
      $display("FAIL stall_count vec%0d: got %0d want %0d", n_vec, hz.stall_count, e.sc);
    end
    if (hz.flush_count !== e.fc) begin
      n_bad++;
      $display("FAIL flush_count vec%0d: got %0d want %0d", n_vec, hz.flush_count, e.fc);
    end
  endtask

  task automatic apply(input vec_t t);
    rst                = t.rst;
    hz.ID_Rs1_address  = t.rs1;
    hz.ID_Rs2_address  = t.rs2;
    hz.EX_Rd_address   = t.rd;
    hz.ID_rs1_used     = t.u1;
    hz.ID_rs2_used     = t.u2;
    hz.EX_MemRead      = t.mr;
    hz.EX_branch_taken = t.bt;
    hz.MEM_dmem_req    = t.req;
    hz.MEM_dmem_ready  = t.rdy;
    sb.push_back(t);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Load-use, x0, unused source, branch priority
    tbl.push_back(rst_v());
    tbl.push_back(idle(0, 0));                                              // startup flush
    tbl.push_back(v(0, 0, 5, 5, 0, 1, 1, 0, 0, 0, LU, 0, 0, 0));
    tbl.push_back(idle(1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, NONE, 0, 1, 0));           // rd = x0
    tbl.push_back(v(0, 7, 0, 7, 0, 0, 1, 0, 0, 0, NONE, 0, 1, 0));           // rs1 unused
    tbl.push_back(v(0, 9, 0, 9, 1, 0, 1, 0, 0, 0, LU, 0, 1, 0));
    tbl.push_back(v(0, 0, 5, 5, 0, 1, 1, 1, 0, 0, FLUSH, 0, 2, 0));          // branch wins
    tbl.push_back(idle(2, 1));
    tbl[1].o = FLUSH;

    // Memory wait with a branch held during the freeze
    tbl.push_back(rst_v());
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLUSH, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE, 0, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, NONE, 0, 3, 0));           // release
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH, 0, 3, 0));          // branch in RUN
    tbl.push_back(idle(3, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 3, 1));           // ready w/o req

    // Timeout into ERROR, then reset recovery
    tbl.push_back(rst_v());
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLUSH, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE, 0, sat(k), 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FREEZE, 1, 15, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 1, 15, 0));
    tbl.push_back(rst_v());
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLUSH, 0, 0, 0));
    tbl.push_back(idle(0, 0));

    // Counter saturation: 20 stall cycles, then 17 branch flushes
    for (int k = 0; k < 20; k++)
      tbl.push_back(v(0, 3, 0, 3, 1, 0, 1, 0, 0, 0, LU, 0, sat(k), 0));
    tbl.push_back(idle(15, 0));
    for (int k = 0; k < 17; k++)
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH, 0, 15, sat(k)));
    tbl.push_back(idle(15, 15));

    // Reset in the middle of a memory wait
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE, 0, 15, 15));
    tbl.push_back(rst_v());
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FLUSH, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 1, 0));

    apply(rst_v());
    foreach (tbl[i]) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
